// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding an Avalon-MM UART transmitter.
// Each grant sends up to BURST bytes from one requester before arbitration reopens.
module uart_tx_sched #(
  parameter int NREQ  = 2,
  parameter int BURST = 4,
  parameter int ADW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              av_write,
  output logic              av_address,
  output logic [ADW/8-1:0]  av_byteenable,
  output logic [ADW-1:0]    av_writedata,
  input  logic              av_waitrequest,
  output logic [2:0]        grant_id,
  output logic              busy
);

  localparam logic [3:0] BURST_MAX = 4'(BURST);
  localparam logic [2:0] LAST_REQ  = 3'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [2:0] last_grant_q, last_grant_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] byte_q, byte_d;

  logic       rr_found;
  int         rr_win;
  logic       cur_valid;
  logic [7:0] cur_data;

  // Scan starts just after the last grant, so a requester that just finished is checked last.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!rr_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
        rr_found = 1'b1;
        rr_win   = (int'(last_grant_q) + k) % NREQ;
      end
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (last_grant_q == 3'(i)) begin
        cur_valid = req_valid[i];
        cur_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    byte_d       = byte_q;
    req_ready    = '0;
    av_write     = 1'b0;
    case (state_q)
      IDLE: begin
        // rst gating keeps req_ready low while reset holds the FSM in IDLE.
        if (rst && rr_found) begin
          req_ready[rr_win] = 1'b1;
          byte_d            = req_data[8*rr_win +: 8];
          last_grant_d      = 3'(rr_win);
          burst_cnt_d       = 4'd1;
          state_d           = WRITE;
        end
      end
      WRITE: begin
        av_write = 1'b1;
        if (!av_waitrequest) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cur_valid && (burst_cnt_q < BURST_MAX)) begin
          for (int i = 0; i < NREQ; i++) begin
            if (last_grant_q == 3'(i)) begin
              req_ready[i] = 1'b1;
            end
          end
          byte_d      = cur_data;
          burst_cnt_d = burst_cnt_q + 4'd1;
          state_d     = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_REQ;
      burst_cnt_q  <= 4'd0;
      byte_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      byte_q       <= byte_d;
    end
  end

  assign av_address    = 1'b0;
  assign av_byteenable = '1;
  assign av_writedata  = {{(ADW-8){1'b0}}, byte_q};
  assign grant_id      = last_grant_q;
  assign busy          = (state_q != IDLE);

endmodule
